// File: rtl/register_file_scoreboard.sv
// Architectural register file with a per-register pending-write scoreboard.
// Decode reserves a destination at issue, and writeback releases it when it writes.
// There are two combinational read ports. Each reports data plus a valid flag so decode can stall on RAW hazards.
// Optional feature: define REGFILE_BYPASS_EN to forward a releasing writeback to the read ports in the same cycle.
module register_file_scoreboard #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned NUM_REGISTERS = 32,
  parameter int unsigned MAX_PENDING   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            write_register,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write_activate,
  input  logic [4:0]            reserve_register,
  input  logic                  reserve_activate,
  output logic                  reserve_ready,
  input  logic [4:0]            read_register_a,
  output logic [DATA_WIDTH-1:0] read_data_a,
  output logic                  read_valid_a,
  input  logic [4:0]            read_register_b,
  output logic [DATA_WIDTH-1:0] read_data_b,
  output logic                  read_valid_b,
  output logic                  scoreboard_error
);

  localparam int unsigned CW = $clog2(MAX_PENDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PENDING);

  logic [DATA_WIDTH-1:0]    regs    [NUM_REGISTERS];
  logic [CW-1:0]            pending [NUM_REGISTERS];
  logic [NUM_REGISTERS-1:0] rel_vec;
  logic [NUM_REGISTERS-1:0] res_vec;
  logic                     reserve_fire;
  logic                     write_unreserved;

  // Accept a reservation when the counter has room.
  // A full counter also accepts when the same index is being released this cycle, because the release is counted first.
  always_comb begin
    reserve_ready = 1'b0;
    if (!rst) begin
      if (reserve_register == '0)
        reserve_ready = 1'b1;
      else if (pending[reserve_register] < MAX_CNT)
        reserve_ready = 1'b1;
      else if (write_activate && (write_register == reserve_register))
        reserve_ready = 1'b1;
    end
  end

  // Handshake and error detection for the current cycle.
  always_comb begin
    reserve_fire     = reserve_activate && reserve_ready;
    write_unreserved = write_activate && (write_register != '0) &&
                       (pending[write_register] == '0);
  end

  // One-hot release/reserve strobes per register; index 0 is never tracked.
  always_comb begin
    rel_vec = '0;
    res_vec = '0;
    for (int unsigned i = 1; i < NUM_REGISTERS; i++) begin
      rel_vec[i] = write_activate && (write_register == 5'(i)) && (pending[i] != '0);
      res_vec[i] = reserve_fire && (reserve_register == 5'(i));
    end
  end

  // Array writes, pending counters, and the sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGISTERS; i++) begin
        regs[i]    <= '0;
        pending[i] <= '0;
      end
      scoreboard_error <= 1'b0;
    end else begin
      if (write_activate && (write_register != '0))
        regs[write_register] <= write_data;
      for (int unsigned i = 1; i < NUM_REGISTERS; i++) begin
        if (rel_vec[i] && !res_vec[i])
          pending[i] <= pending[i] - CW'(1);
        else if (res_vec[i] && !rel_vec[i])
          pending[i] <= pending[i] + CW'(1);
      end
      if (write_unreserved)
        scoreboard_error <= 1'b1;
    end
  end

  // Read port A: x0 reads as zero, and data is final once no write is pending.
  always_comb begin
    read_data_a  = regs[read_register_a];
    read_valid_a = (pending[read_register_a] == '0);
    if (read_register_a == '0) begin
      read_data_a  = '0;
      read_valid_a = 1'b1;
    end
`ifdef REGFILE_BYPASS_EN
    else if (write_activate && (write_register == read_register_a) &&
             (pending[read_register_a] == CW'(1))) begin
      read_data_a  = write_data;
      read_valid_a = 1'b1;
    end
`endif
    if (rst)
      read_valid_a = 1'b0;
  end

  // Read port B: same rules as port A.
  always_comb begin
    read_data_b  = regs[read_register_b];
    read_valid_b = (pending[read_register_b] == '0);
    if (read_register_b == '0) begin
      read_data_b  = '0;
      read_valid_b = 1'b1;
    end
`ifdef REGFILE_BYPASS_EN
    else if (write_activate && (write_register == read_register_b) &&
             (pending[read_register_b] == CW'(1))) begin
      read_data_b  = write_data;
      read_valid_b = 1'b1;
    end
`endif
    if (rst)
      read_valid_b = 1'b0;
  end

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Directed self-checking bench for register_file_scoreboard.
// Expected values follow the build mode selected by REGFILE_BYPASS_EN.
module tb_register_file_scoreboard;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic        write_activate;
  logic [4:0]  reserve_register;
  logic        reserve_activate;
  logic        reserve_ready;
  logic [4:0]  read_register_a;
  logic [31:0] read_data_a;
  logic        read_valid_a;
  logic [4:0]  read_register_b;
  logic [31:0] read_data_b;
  logic        read_valid_b;
  logic        scoreboard_error;

  int checks = 0;
  int errors = 0;

  register_file_scoreboard #(
    .DATA_WIDTH(32),
    .NUM_REGISTERS(32),
    .MAX_PENDING(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .write_register(write_register),
    .write_data(write_data),
    .write_activate(write_activate),
    .reserve_register(reserve_register),
    .reserve_activate(reserve_activate),
    .reserve_ready(reserve_ready),
    .read_register_a(read_register_a),
    .read_data_a(read_data_a),
    .read_valid_a(read_valid_a),
    .read_register_b(read_register_b),
    .read_data_b(read_data_b),
    .read_valid_b(read_valid_b),
    .scoreboard_error(scoreboard_error)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write_activate   = 1'b0;
    write_register   = '0;
    write_data       = '0;
    reserve_activate = 1'b0;
    reserve_register = '0;
  endtask

  task automatic test_reset();
    read_register_a = 5'd5;
    write_activate = 1'b1; write_register = 5'd5; write_data = 32'hDEAD;
    step();
    idle();
    rst = 1'b1;
    reserve_activate = 1'b1; reserve_register = 5'd5;
    #1;
    checks++; if (reserve_ready !== 1'b0) begin errors++; $display("FAIL rst_ready actual %b required 0", reserve_ready); end
    checks++; if (read_data_a !== 32'hDEAD) begin errors++; $display("FAIL rst_data_pre actual %h required 0000dead", read_data_a); end
    checks++; if (read_valid_a !== 1'b0) begin errors++; $display("FAIL rst_valid_pre actual %b required 0", read_valid_a); end
    step();
    checks++; if (read_data_a !== 32'h0) begin errors++; $display("FAIL rst_data actual %h required 0", read_data_a); end
    checks++; if (read_valid_a !== 1'b0) begin errors++; $display("FAIL rst_valid actual %b required 0", read_valid_a); end
    checks++; if (scoreboard_error !== 1'b0) begin errors++; $display("FAIL rst_error actual %b required 0", scoreboard_error); end
    step();
    rst = 1'b0;
    reserve_activate = 1'b0;
    #1;
    checks++; if (read_data_a !== 32'h0 || read_valid_a !== 1'b1) begin errors++; $display("FAIL post_rst_read actual %h/%b required 0/1", read_data_a, read_valid_a); end
    checks++; if (reserve_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready actual %b required 1", reserve_ready); end
    step();
  endtask

  task automatic test_basic();
    read_register_a = 5'd3;
    reserve_activate = 1'b1; reserve_register = 5'd3;
    #1;
    checks++; if (reserve_ready !== 1'b1) begin errors++; $display("FAIL basic_ready actual %b required 1", reserve_ready); end
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (read_valid_a !== 1'b0) begin errors++; $display("FAIL basic_wait%0d actual %b required 0", i, read_valid_a); end
      step();
    end
    write_activate = 1'b1; write_register = 5'd3; write_data = 32'h1234;
    #1;
    checks++; if (read_valid_a !== BYP || read_data_a !== (BYP ? 32'h1234 : 32'h0)) begin errors++; $display("FAIL basic_wb_cycle actual %h/%b required %h/%b", read_data_a, read_valid_a, (BYP ? 32'h1234 : 32'h0), BYP); end
    step();
    idle();
    #1;
    checks++; if (read_valid_a !== 1'b1 || read_data_a !== 32'h1234) begin errors++; $display("FAIL basic_after actual %h/%b required 00001234/1", read_data_a, read_valid_a); end
    step();
  endtask

  task automatic test_saturation();
    read_register_a = 5'd7;
    reserve_register = 5'd7;
    for (int i = 0; i < 3; i++) begin
      reserve_activate = 1'b1;
      #1;
      checks++; if (reserve_ready !== 1'b1) begin errors++; $display("FAIL sat_res%0d actual %b required 1", i, reserve_ready); end
      step();
    end
    #1;
    checks++; if (reserve_ready !== 1'b0) begin errors++; $display("FAIL sat_full actual %b required 0", reserve_ready); end
    step();
    write_activate = 1'b1; write_register = 5'd7; write_data = 32'h70;
    #1;
    checks++; if (reserve_ready !== 1'b1) begin errors++; $display("FAIL sat_res_rel actual %b required 1", reserve_ready); end
    step();
    idle();
    reserve_register = 5'd7;
    #1;
    checks++; if (reserve_ready !== 1'b0) begin errors++; $display("FAIL sat_still_full actual %b required 0", reserve_ready); end
    checks++; if (read_valid_a !== 1'b0) begin errors++; $display("FAIL sat_valid3 actual %b required 0", read_valid_a); end
    for (int i = 0; i < 3; i++) begin
      write_activate = 1'b1; write_register = 5'd7; write_data = 32'h71 + i;
      step();
      idle();
      reserve_register = 5'd7;
      #1;
      checks++; if (reserve_ready !== 1'b1) begin errors++; $display("FAIL sat_drain%0d_ready actual %b required 1", i, reserve_ready); end
    end
    checks++; if (read_valid_a !== 1'b1 || read_data_a !== 32'h73) begin errors++; $display("FAIL sat_final actual %h/%b required 00000073/1", read_data_a, read_valid_a); end
    checks++; if (scoreboard_error !== 1'b0) begin errors++; $display("FAIL sat_error actual %b required 0", scoreboard_error); end
    step();
  endtask

  task automatic test_x0();
    read_register_a = 5'd0;
    reserve_activate = 1'b1; reserve_register = 5'd0;
    #1;
    checks++; if (reserve_ready !== 1'b1) begin errors++; $display("FAIL x0_ready actual %b required 1", reserve_ready); end
    step();
    idle();
    write_activate = 1'b1; write_register = 5'd0; write_data = 32'hFFFF_FFFF;
    step();
    idle();
    #1;
    checks++; if (read_data_a !== 32'h0 || read_valid_a !== 1'b1) begin errors++; $display("FAIL x0_read actual %h/%b required 0/1", read_data_a, read_valid_a); end
    checks++; if (scoreboard_error !== 1'b0) begin errors++; $display("FAIL x0_error actual %b required 0", scoreboard_error); end
    step();
  endtask

  task automatic test_dual_port();
    reserve_activate = 1'b1; reserve_register = 5'd4;
    step();
    idle();
    read_register_a = 5'd4; read_register_b = 5'd4;
    write_activate = 1'b1; write_register = 5'd4; write_data = 32'hA5;
    #1;
    checks++; if (read_data_a !== (BYP ? 32'hA5 : 32'h0) || read_valid_a !== BYP) begin errors++; $display("FAIL dual_a actual %h/%b required %h/%b", read_data_a, read_valid_a, (BYP ? 32'hA5 : 32'h0), BYP); end
    checks++; if (read_data_b !== (BYP ? 32'hA5 : 32'h0) || read_valid_b !== BYP) begin errors++; $display("FAIL dual_b actual %h/%b required %h/%b", read_data_b, read_valid_b, (BYP ? 32'hA5 : 32'h0), BYP); end
    step();
    idle();
    #1;
    checks++; if (read_data_b !== 32'hA5 || read_valid_b !== 1'b1) begin errors++; $display("FAIL dual_after actual %h/%b required 000000a5/1", read_data_b, read_valid_b); end
    reserve_activate = 1'b1; reserve_register = 5'd6;
    step();
    reserve_activate = 1'b1; reserve_register = 5'd2;
    write_activate = 1'b1; write_register = 5'd6; write_data = 32'h66;
    step();
    idle();
    read_register_a = 5'd2; read_register_b = 5'd6;
    #1;
    checks++; if (read_valid_a !== 1'b0) begin errors++; $display("FAIL simul_res_x2 actual %b required 0", read_valid_a); end
    checks++; if (read_data_b !== 32'h66 || read_valid_b !== 1'b1) begin errors++; $display("FAIL simul_wr_x6 actual %h/%b required 00000066/1", read_data_b, read_valid_b); end
    checks++; if (scoreboard_error !== 1'b0) begin errors++; $display("FAIL simul_error actual %b required 0", scoreboard_error); end
    step();
  endtask

  task automatic test_error();
    read_register_a = 5'd9;
    write_activate = 1'b1; write_register = 5'd9; write_data = 32'h55;
    #1;
    checks++; if (scoreboard_error !== 1'b0) begin errors++; $display("FAIL err_before actual %b required 0", scoreboard_error); end
    step();
    idle();
    #1;
    checks++; if (scoreboard_error !== 1'b1) begin errors++; $display("FAIL err_set actual %b required 1", scoreboard_error); end
    checks++; if (read_data_a !== 32'h55 || read_valid_a !== 1'b1) begin errors++; $display("FAIL err_read actual %h/%b required 00000055/1", read_data_a, read_valid_a); end
    step(); step();
    checks++; if (scoreboard_error !== 1'b1) begin errors++; $display("FAIL err_sticky actual %b required 1", scoreboard_error); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++; if (scoreboard_error !== 1'b0) begin errors++; $display("FAIL err_cleared actual %b required 0", scoreboard_error); end
    step();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    read_register_a = '0;
    read_register_b = '0;
    step(); step();
    rst = 1'b0;
    step();
    test_reset();
    test_basic();
    test_saturation();
    test_x0();
    test_dual_port();
    test_error();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
